// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: reset sequencing, run gating, halt detection and {pc, ir} trace.
// Define MIPS_RUN_TRACE_EN to build the trace buffer and its read port.
module mips_run_ctrl #(
    parameter int          PC_W        = 32,
    parameter int          IR_W        = 32,
    parameter int          RST_CYCLES  = 2,
    parameter int          MAX_CYCLES  = 1024,
    parameter int          STALL_LIMIT = 4,
    parameter logic [31:0] HALT_WORD   = 32'h0000000C,
    parameter int          TRACE_DEPTH = 16,
    parameter int          CNT_W       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [PC_W-1:0]              pc,
    input  logic [IR_W-1:0]              ir,
    output logic                         cpu_rst_n,
    output logic                         cpu_en,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   halt_cause,
    output logic [CNT_W-1:0]             cycle_count,
    input  logic                         trace_rd_en,
    output logic [PC_W+IR_W-1:0]         trace_rd_data,
    output logic                         trace_rd_valid,
    output logic [$clog2(TRACE_DEPTH):0] trace_count,
    output logic                         trace_overflow
);

    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam int SW   = $clog2(STALL_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
    logic [SW-1:0]     stall_cnt_q, stall_cnt_d;
    logic [PC_W-1:0]   prev_pc_q, prev_pc_d;
    logic              have_prev_q, have_prev_d;
    logic [1:0]        cause_q, cause_d;

    logic              clear;
    logic              run_wr;
    logic              pc_eq;
    logic              hit_word;
    logic              hit_stall;
    logic              hit_budget;

    // A PC seen on STALL_LIMIT consecutive RUN cycles is a self-loop halt.
    assign pc_eq      = have_prev_q && (pc == prev_pc_q);
    assign hit_word   = (ir == IR_W'(HALT_WORD));
    assign hit_stall  = pc_eq && (stall_cnt_q + SW'(1) >= SW'(STALL_LIMIT - 1));
    assign hit_budget = ({1'b0, cycle_cnt_q} + (CNT_W+1)'(1)) == (CNT_W+1)'(MAX_CYCLES);

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        stall_cnt_d = stall_cnt_q;
        prev_pc_d   = prev_pc_q;
        have_prev_d = have_prev_q;
        cause_d     = cause_q;
        clear       = 1'b0;
        run_wr      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RESET;
                    clear   = 1'b1;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) begin
                    state_d = S_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                end
            end
            S_RUN: begin
                run_wr      = 1'b1;
                prev_pc_d   = pc;
                have_prev_d = 1'b1;
                stall_cnt_d = pc_eq ? stall_cnt_q + SW'(1) : '0;
                if (cycle_cnt_q != '1) begin
                    cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                end
                if (hit_word) begin
                    cause_d = 2'd1;
                    state_d = S_DONE;
                end else if (hit_stall) begin
                    cause_d = 2'd2;
                    state_d = S_DONE;
                end else if (hit_budget) begin
                    cause_d = 2'd3;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_d = S_RESET;
                    clear   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            rst_cnt_d   = '0;
            cycle_cnt_d = '0;
            stall_cnt_d = '0;
            have_prev_d = 1'b0;
            cause_d     = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rst_cnt_q   <= '0;
            cycle_cnt_q <= '0;
            stall_cnt_q <= '0;
            prev_pc_q   <= '0;
            have_prev_q <= 1'b0;
            cause_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            prev_pc_q   <= prev_pc_d;
            have_prev_q <= have_prev_d;
            cause_q     <= cause_d;
        end
    end

    // Core reset is released once RESET finishes and stays released in DONE.
    assign cpu_rst_n   = (state_q == S_RUN) || (state_q == S_DONE);
    assign cpu_en      = (state_q == S_RUN);
    assign busy        = (state_q == S_RESET) || (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign halt_cause  = cause_q;
    assign cycle_count = cycle_cnt_q;

`ifdef MIPS_RUN_TRACE_EN
    localparam int PTR_W = $clog2(TRACE_DEPTH);
    localparam int CW    = PTR_W + 1;
    localparam int TW    = PC_W + IR_W;

    logic [TW-1:0]    mem [TRACE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    tcnt_q, tcnt_d;
    logic             ovf_q, ovf_d;
    logic [TW-1:0]    rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_fire;

    assign rd_fire = (state_q == S_DONE) && trace_rd_en && (tcnt_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tcnt_d     = tcnt_q;
        ovf_d      = ovf_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (clear) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            tcnt_d    = '0;
            ovf_d     = 1'b0;
            rd_data_d = '0;
        end else if (run_wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            // Full: the oldest entry is overwritten, so the read side advances.
            if (tcnt_q == CW'(TRACE_DEPTH)) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                ovf_d    = 1'b1;
            end else begin
                tcnt_d = tcnt_q + CW'(1);
            end
        end else if (rd_fire) begin
            rd_data_d  = mem[rd_ptr_q];
            rd_valid_d = 1'b1;
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            tcnt_d     = tcnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (run_wr) begin
            mem[wr_ptr_q] <= {pc, ir};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tcnt_q     <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tcnt_q     <= tcnt_d;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign trace_rd_data  = rd_data_q;
    assign trace_rd_valid = rd_valid_q;
    assign trace_count    = tcnt_q;
    assign trace_overflow = ovf_q;
`else
    logic unused_trace;
    assign unused_trace   = ^{trace_rd_en, run_wr};
    assign trace_rd_data  = '0;
    assign trace_rd_valid = 1'b0;
    assign trace_count    = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: reset, start timing, the three halt causes, trace drain and mid-run reset.
// Trace expectations follow MIPS_RUN_TRACE_EN.
module tb_mips_run_ctrl;

    localparam int MAXC = 20;
    localparam logic [31:0] HALT = 32'h0000000C;
`ifdef MIPS_RUN_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        cpu_rst_n;
    logic        cpu_en;
    logic        busy;
    logic        done;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;
    logic        trace_rd_en;
    logic [63:0] trace_rd_data;
    logic        trace_rd_valid;
    logic [4:0]  trace_count;
    logic        trace_overflow;

    int total;
    int bad;
    int rv_seen;

    mips_run_ctrl #(
        .PC_W        (32),
        .IR_W        (32),
        .RST_CYCLES  (2),
        .MAX_CYCLES  (MAXC),
        .STALL_LIMIT (4),
        .HALT_WORD   (HALT),
        .TRACE_DEPTH (16),
        .CNT_W       (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .pc             (pc),
        .ir             (ir),
        .cpu_rst_n      (cpu_rst_n),
        .cpu_en         (cpu_en),
        .busy           (busy),
        .done           (done),
        .halt_cause     (halt_cause),
        .cycle_count    (cycle_count),
        .trace_rd_en    (trace_rd_en),
        .trace_rd_data  (trace_rd_data),
        .trace_rd_valid (trace_rd_valid),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (trace_rd_valid) rv_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rstn"}, 64'(cpu_rst_n), 64'd0);
        chk({tag, "_en"}, 64'(cpu_en), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_cause"}, 64'(halt_cause), 64'd0);
        chk({tag, "_ccnt"}, 64'(cycle_count), 64'd0);
        chk({tag, "_rdat"}, trace_rd_data, 64'd0);
        chk({tag, "_rval"}, 64'(trace_rd_valid), 64'd0);
        chk({tag, "_tcnt"}, 64'(trace_count), 64'd0);
        chk({tag, "_ovf"}, 64'(trace_overflow), 64'd0);
    endtask

    // Pulse start and walk through RESET; returns in RUN cycle 1.
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
    endtask

    initial begin
        total = 0;
        bad = 0;
        rv_seen = 0;
        rst = 1'b1;
        start = 1'b0;
        pc = '0;
        ir = '0;
        trace_rd_en = 1'b0;
        step();
        step();
        chk_reset_vals("por");
        rst = 1'b0;
        step();

        // start timing and HALT_WORD on RUN cycle 5
        start = 1'b1;
        step();
        start = 1'b0;
        chk("c1_busy", 64'(busy), 64'd1);
        chk("c1_rstn", 64'(cpu_rst_n), 64'd0);
        chk("c1_en", 64'(cpu_en), 64'd0);
        step();
        chk("c2_rstn", 64'(cpu_rst_n), 64'd0);
        chk("c2_en", 64'(cpu_en), 64'd0);
        step();
        chk("c3_rstn", 64'(cpu_rst_n), 64'd1);
        chk("c3_en", 64'(cpu_en), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            pc = 32'(4 * (k - 1));
            ir = (k == 5) ? HALT : 32'h2000_0000 + 32'(k);
            step();
        end
        chk("hw_done", 64'(done), 64'd1);
        chk("hw_en", 64'(cpu_en), 64'd0);
        chk("hw_rstn", 64'(cpu_rst_n), 64'd1);
        chk("hw_busy", 64'(busy), 64'd0);
        chk("hw_cause", 64'(halt_cause), 64'd1);
        chk("hw_ccnt", 64'(cycle_count), 64'd5);
        chk("hw_tcnt", 64'(trace_count), TR ? 64'd5 : 64'd0);
        trace_rd_en = 1'b1;
        step();
        trace_rd_en = 1'b0;
        chk("hw_rval", 64'(trace_rd_valid), TR ? 64'd1 : 64'd0);
        chk("hw_rdat", trace_rd_data,
            TR ? 64'h0000_0000_2000_0001 : 64'd0);
        chk("hw_tcnt1", 64'(trace_count), TR ? 64'd4 : 64'd0);
        step();
        chk("hw_rval0", 64'(trace_rd_valid), 64'd0);

        // PC self-loop at 0x10 from RUN cycle 3; start in RUN is ignored
        do_start();
        for (int k = 1; k <= 6; k++) begin
            pc = (k == 1) ? 32'h8 : (k == 2) ? 32'hC : 32'h10;
            ir = 32'h0;
            start = (k == 2);
            step();
            if (k == 5) chk("st_early", 64'(done), 64'd0);
        end
        start = 1'b0;
        chk("st_done", 64'(done), 64'd1);
        chk("st_cause", 64'(halt_cause), 64'd2);
        chk("st_ccnt", 64'(cycle_count), 64'd6);
        chk("st_tcnt", 64'(trace_count), TR ? 64'd6 : 64'd0);

        // cycle budget with trace wrap, then drain
        do_start();
        for (int k = 1; k <= MAXC; k++) begin
            pc = 32'(4 * (k - 1));
            ir = 32'h100 + 32'(k);
            step();
            if (k == MAXC - 1) chk("bg_early", 64'(done), 64'd0);
        end
        chk("bg_done", 64'(done), 64'd1);
        chk("bg_cause", 64'(halt_cause), 64'd3);
        chk("bg_ccnt", 64'(cycle_count), 64'd20);
        chk("bg_tcnt", 64'(trace_count), TR ? 64'd16 : 64'd0);
        chk("bg_ovf", 64'(trace_overflow), TR ? 64'd1 : 64'd0);
        trace_rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            chk("dr_val", 64'(trace_rd_valid), TR ? 64'd1 : 64'd0);
            chk("dr_pc", 64'(trace_rd_data[63:32]),
                TR ? 64'(32'h10 + 32'(4 * i)) : 64'd0);
            chk("dr_ir", 64'(trace_rd_data[31:0]),
                TR ? 64'(32'h105 + 32'(i)) : 64'd0);
        end
        step();
        trace_rd_en = 1'b0;
        chk("dr_empty_val", 64'(trace_rd_valid), 64'd0);
        chk("dr_empty_cnt", 64'(trace_count), 64'd0);

        // rst during RUN cycle 7, then a clean rerun
        do_start();
        for (int k = 1; k <= 6; k++) begin
            pc = 32'h400 + 32'(4 * k);
            ir = 32'h0;
            step();
        end
        chk("mr_busy", 64'(busy), 64'd1);
        chk("mr_ccnt", 64'(cycle_count), 64'd6);
        pc = 32'h500;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset_vals("mr");
        do_start();
        chk("rr_ccnt0", 64'(cycle_count), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            pc = 32'h40 + 32'(4 * k);
            ir = (k == 3) ? HALT : 32'h0;
            step();
        end
        chk("rr_cause", 64'(halt_cause), 64'd1);
        chk("rr_ccnt", 64'(cycle_count), 64'd3);
        chk("rr_tcnt", 64'(trace_count), TR ? 64'd3 : 64'd0);
        chk("rr_ovf", 64'(trace_overflow), 64'd0);
        step();
        chk("rv_total", 64'(rv_seen), TR ? 64'd17 : 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
